instruc_mem_pipe: RTL and testbench

Parametrised successor to the single-cycle instruction memory top. It accepts one request per cycle (read or byte-masked write) through a request/ready handshake. Read latency is configurable, and responses are delivered in order through a valid/resp_ready channel backed by a response FIFO. It sits between the fetch/LSU request logic and the memory array, supports backpressure, and flags out-of-range addresses.

---
 rtl/instruc_mem_pipe.sv | 169 ++++++++++++++++
 tb/tb_instruc_mem_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruc_mem_pipe.sv
// instruc_mem_pipe: word memory with a request/ready front end, a configurable
// read-latency pipeline and an in-order first-word-fall-through response FIFO
// whose occupancy is bounded by a credit counter.
module instruc_mem_pipe #(
    parameter bit          INIT_MEM   = 1'b0,
    parameter string       INIT_FILE  = "",
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned Address    = 8,
    parameter int unsigned DEPTH      = 2**Address,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   request,
    output logic                   ready,
    input  logic                   we_re,
    input  logic [DataWidth/8-1:0] mask,
    input  logic [Address-1:0]     address,
    input  logic [DataWidth-1:0]   data_in,
    output logic                   valid,
    input  logic                   resp_ready,
    output logic [DataWidth-1:0]   data_out,
    output logic                   resp_we,
    output logic                   resp_err
);

    localparam int unsigned NB = DataWidth / 8;
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam logic [Address:0] DEPTH_W  = (Address + 1)'(DEPTH);
    localparam logic [PW-1:0]    LAST_PTR = PW'(RESP_DEPTH - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(RESP_DEPTH);

    logic                 accept, in_range, wr_en, pop, push;
    logic                 push_we, push_err;
    logic [DataWidth-1:0] s0_data, push_data;
    logic [CW-1:0]        cnt_q, cnt_d, fcnt_q, fcnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    logic [DataWidth-1:0] mem    [DEPTH];
    logic [DataWidth-1:0] fd_q   [RESP_DEPTH];
    logic                 fwe_q  [RESP_DEPTH];
    logic                 ferr_q [RESP_DEPTH];

    // ready comes only from the registered credit count
    assign ready    = (cnt_q < FULL_CNT);
    assign valid    = (fcnt_q != '0);
    assign accept   = request && ready;
    assign pop      = valid && resp_ready;
    assign in_range = ({1'b0, address} < DEPTH_W);
    assign wr_en    = rst && accept && we_re && in_range;

    // Response payload formed on the accept edge: array value before any write
    always_comb begin
        s0_data = '0;
        if (!we_re && in_range) begin
            s0_data = mem[address];
        end
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (mask[b]) begin
                    mem[address][b*8 +: 8] <= data_in[b*8 +: 8];
                end
            end
        end
    end

    if (LATENCY > 1) begin : g_pipe
        localparam int unsigned PS = LATENCY - 1;
        logic [PS-1:0]        pv_q, pwe_q, perr_q;
        logic [DataWidth-1:0] pd_q [PS];

        // Carry accepted requests through LATENCY-1 register stages
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv_q   <= '0;
                pwe_q  <= '0;
                perr_q <= '0;
                for (int i = 0; i < PS; i++) begin
                    pd_q[i] <= '0;
                end
            end else begin
                pv_q[0]   <= accept;
                pwe_q[0]  <= we_re;
                perr_q[0] <= !in_range;
                pd_q[0]   <= s0_data;
                for (int i = 1; i < PS; i++) begin
                    pv_q[i]   <= pv_q[i-1];
                    pwe_q[i]  <= pwe_q[i-1];
                    perr_q[i] <= perr_q[i-1];
                    pd_q[i]   <= pd_q[i-1];
                end
            end
        end

        assign push      = pv_q[PS-1];
        assign push_we   = pwe_q[PS-1];
        assign push_err  = perr_q[PS-1];
        assign push_data = pd_q[PS-1];
    end else begin : g_nopipe
        assign push      = accept;
        assign push_we   = we_re;
        assign push_err  = !in_range;
        assign push_data = s0_data;
    end

    // Next-state for FIFO pointers, FIFO occupancy and credit count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fcnt_d   = fcnt_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + CW'(1);
            2'b01:   fcnt_d = fcnt_q - CW'(1);
            default: fcnt_d = fcnt_q;
        endcase
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; entries are only visible through the valid-gated head
    always_ff @(posedge clk) begin
        if (push) begin
            fd_q[wr_ptr_q]   <= push_data;
            fwe_q[wr_ptr_q]  <= push_we;
            ferr_q[wr_ptr_q] <= push_err;
        end
    end

    assign data_out = valid ? fd_q[rd_ptr_q] : '0;
    assign resp_we  = valid && fwe_q[rd_ptr_q];
    assign resp_err = valid && ferr_q[rd_ptr_q];

    // Credits bound occupancy, so a push never lands on a full FIFO without a pop
    assert property (@(posedge clk) disable iff (!rst)
                     !(push && !pop && (fcnt_q == FULL_CNT)))
        else $error("instruc_mem_pipe: response FIFO overflow");

endmodule

// File: tb/tb_instruc_mem_pipe.sv
// tb_instruc_mem_pipe: three instances (LATENCY 1/2/3) share one stimulus stream;
// a list-based reference model checks every cycle, and directed sequences cover
// reset, masked writes, backpressure, out-of-range and throughput corners.
`timescale 1ns/1ps
module tb_instruc_mem_pipe;

    localparam int NDUT = 3;

    function automatic int lat_of(input int n);
        return n + 1;
    endfunction
    function automatic int rd_of(input int n);
        return (n == 2) ? 5 : 4;
    endfunction
    function automatic int dep_of(input int n);
        return (n == 0) ? 200 : 256;
    endfunction
    function automatic logic [31:0] fill(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, b ^ 8'h5A, 8'h3C};
    endfunction
    function automatic logic [31:0] exp_word(input int a);
        return (a == 5) ? 32'hDE22BE44 : fill(a);
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        request = 1'b0;
    logic        we_re = 1'b0;
    logic        resp_ready = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [7:0]  address = 8'h0;
    logic [31:0] data_in = 32'h0;

    logic [NDUT-1:0]       rdy, vld, rwe, rerr;
    logic [NDUT-1:0][31:0] dout;

    always #5 clk = ~clk;

    instruc_mem_pipe #(.INIT_MEM(1'b0), .INIT_FILE(""), .DataWidth(32), .Address(8),
                       .DEPTH(200), .LATENCY(1), .RESP_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .request(request), .ready(rdy[0]), .we_re(we_re),
        .mask(mask), .address(address), .data_in(data_in), .valid(vld[0]),
        .resp_ready(resp_ready), .data_out(dout[0]), .resp_we(rwe[0]), .resp_err(rerr[0]));

    instruc_mem_pipe #(.INIT_MEM(1'b0), .INIT_FILE(""), .DataWidth(32), .Address(8),
                       .DEPTH(256), .LATENCY(2), .RESP_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .request(request), .ready(rdy[1]), .we_re(we_re),
        .mask(mask), .address(address), .data_in(data_in), .valid(vld[1]),
        .resp_ready(resp_ready), .data_out(dout[1]), .resp_we(rwe[1]), .resp_err(rerr[1]));

    instruc_mem_pipe #(.INIT_MEM(1'b0), .INIT_FILE(""), .DataWidth(32), .Address(8),
                       .DEPTH(256), .LATENCY(3), .RESP_DEPTH(5)) u2 (
        .clk(clk), .rst(rst), .request(request), .ready(rdy[2]), .we_re(we_re),
        .mask(mask), .address(address), .data_in(data_in), .valid(vld[2]),
        .resp_ready(resp_ready), .data_out(dout[2]), .resp_we(rwe[2]), .resp_err(rerr[2]));

    int ncmp = 0;
    int nerr = 0;

    function automatic void chk(input string nm, input int n, input logic [31:0] act,
                                input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s [%0d] got %h want %h at %0t", nm, n, act, exp, $time);
        end
    endfunction

    // Reference model: per instance, a list of accepted-but-unpopped responses,
    // each tagged with the edge after which it may be shown at the head.
    logic [31:0] mm   [NDUT][256];
    logic [31:0] qd   [NDUT][32];
    bit          qwe  [NDUT][32];
    bit          qerr [NDUT][32];
    longint      qel  [NDUT][32];
    int          qn   [NDUT];
    longint      cyc = 0;
    bit          m_rdy, m_vld, m_inr, c_vld;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < NDUT; n++) qn[n] = 0;
        end else begin
            cyc = cyc + 1;
            for (int n = 0; n < NDUT; n++) begin
                m_rdy = (qn[n] < rd_of(n));
                m_vld = (qn[n] > 0) && (qel[n][0] <= cyc - 1);
                if (m_vld && resp_ready) begin
                    for (int i = 0; i < qn[n] - 1; i++) begin
                        qd[n][i]   = qd[n][i+1];
                        qwe[n][i]  = qwe[n][i+1];
                        qerr[n][i] = qerr[n][i+1];
                        qel[n][i]  = qel[n][i+1];
                    end
                    qn[n] = qn[n] - 1;
                end
                if (request && m_rdy) begin
                    m_inr = (int'(address) < dep_of(n));
                    qd[n][qn[n]]   = (!we_re && m_inr) ? mm[n][address] : 32'h0;
                    qwe[n][qn[n]]  = we_re;
                    qerr[n][qn[n]] = !m_inr;
                    qel[n][qn[n]]  = cyc + longint'(lat_of(n)) - 1;
                    qn[n] = qn[n] + 1;
                    if (we_re && m_inr) begin
                        for (int b = 0; b < 4; b++)
                            if (mask[b]) mm[n][address][b*8 +: 8] = data_in[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int n = 0; n < NDUT; n++) begin
            c_vld = (qn[n] > 0) && (qel[n][0] <= cyc);
            chk("ready", n, 32'(rdy[n]), 32'(qn[n] < rd_of(n)));
            chk("valid", n, 32'(vld[n]), 32'(c_vld));
            chk("data_out", n, dout[n], c_vld ? qd[n][0] : 32'h0);
            chk("resp_we", n, 32'(rwe[n]), 32'(c_vld && qwe[n][0]));
            chk("resp_err", n, 32'(rerr[n]), 32'(c_vld && qerr[n][0]));
        end
    end

    typedef struct {
        logic        we;
        logic [3:0]  mask;
        logic [7:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_data;
        logic        exp_we;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] got [$];
    logic [31:0] g;
    int          w, acc, stale;
    bit          low_seen, a_now, exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'hF, 8'd5,   32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
        tbl[1] = '{1'b0, 4'h0, 8'd5,   32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 4'h5, 8'd5,   32'h11223344, 32'h0,        1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'h0, 8'd5,   32'h0,        32'hDE22BE44, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 8'd250, 32'h0,        32'h0,        1'b0, 1'b1};
        tbl[5] = '{1'b1, 4'hF, 8'd250, 32'h12345678, 32'h0,        1'b1, 1'b1};
        tbl[6] = '{1'b0, 4'h0, 8'd250, 32'h0,        32'h0,        1'b0, 1'b1};
        tbl[7] = '{1'b0, 4'h0, 8'd199, 32'h0,        fill(199),    1'b0, 1'b0};

        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < NDUT; n++) begin
            chk("rst_ready", n, 32'(rdy[n]), 32'h1);
            chk("rst_valid", n, 32'(vld[n]), 32'h0);
            chk("rst_dout", n, dout[n], 32'h0);
        end
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;

        // Fill every word with a known pattern, back to back
        for (int a = 0; a < 256; a++) begin
            request = 1'b1; we_re = 1'b1; mask = 4'hF;
            address = 8'(a); data_in = fill(a);
            tick();
        end
        request = 1'b0; we_re = 1'b0;
        repeat (8) tick();

        // Vector table on the LATENCY=1, DEPTH=200 instance
        for (int i = 0; i < 8; i++) begin
            request = 1'b1; we_re = tbl[i].we; mask = tbl[i].mask;
            address = tbl[i].addr; data_in = tbl[i].din;
            tick();
            request = 1'b0;
            w = 0;
            @(negedge clk);
            while (!vld[0] && w < 10) begin
                w++;
                @(negedge clk);
            end
            chk("tbl_latency", i, 32'(w), 32'h0);
            chk("tbl_data", i, dout[0], tbl[i].exp_data);
            chk("tbl_we", i, 32'(rwe[0]), 32'(tbl[i].exp_we));
            chk("tbl_err", i, 32'(rerr[0]), 32'(tbl[i].exp_err));
            repeat (5) tick();
        end

        // Sweep every in-range word after the out-of-range write
        for (int a = 0; a < 200; a++) begin
            request = 1'b1; we_re = 1'b0; address = 8'(a);
            tick();
        end
        request = 1'b0;
        repeat (8) tick();

        // Reset with three reads outstanding
        resp_ready = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            request = 1'b1; we_re = 1'b0; address = 8'(a);
            tick();
        end
        request = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        for (int n = 0; n < NDUT; n++) begin
            chk("midrst_ready", n, 32'(rdy[n]), 32'h1);
            chk("midrst_valid", n, 32'(vld[n]), 32'h0);
            chk("midrst_dout", n, dout[n], 32'h0);
        end
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (vld != '0) stale++;
        end
        chk("stale_resp", 0, 32'(stale), 32'h0);
        tick();
        request = 1'b1; we_re = 1'b0; address = 8'd5;
        tick();
        request = 1'b0;
        @(negedge clk);
        chk("post_rst_read", 0, dout[0], 32'hDE22BE44);
        repeat (8) tick();

        // Backpressure on the LATENCY=2, RESP_DEPTH=4 instance
        resp_ready = 1'b0; we_re = 1'b0; mask = 4'h0;
        acc = 0; low_seen = 1'b0;
        got.delete();
        for (int c = 0; c < 80 && got.size() < 6; c++) begin
            address = 8'(acc);
            request = (acc < 6);
            @(negedge clk);
            if (!resp_ready && acc < 4) chk("bp_ready_hi", acc, 32'(rdy[1]), 32'h1);
            if (acc == 4 && !resp_ready && !low_seen) begin
                chk("bp_ready_low", 1, 32'(rdy[1]), 32'h0);
                low_seen = 1'b1;
            end
            a_now = request && rdy[1];
            if (vld[1] && resp_ready) got.push_back(dout[1]);
            tick();
            if (a_now) acc++;
            if (low_seen) resp_ready = 1'b1;
        end
        request = 1'b0;
        chk("bp_count", 1, 32'(got.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            g = (j < got.size()) ? got[j] : 32'hFFFF_FFFF;
            chk("bp_order", j, g, exp_word(j));
        end
        resp_ready = 1'b1;
        repeat (10) tick();

        // Throughput on the LATENCY=3 instance
        request = 1'b1; we_re = 1'b0; address = 8'd20;
        @(negedge clk);
        chk("tp_ready_pre", 2, 32'(rdy[2]), 32'h1);
        #1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (t < 15) address = 8'(21 + t);
            else request = 1'b0;
            @(negedge clk);
            if (t < 16) chk("tp_ready", t, 32'(rdy[2]), 32'h1);
            exp_v = (t >= 2) && (t < 18);
            chk("tp_valid", t, 32'(vld[2]), 32'(exp_v));
            chk("tp_data", t, dout[2], exp_v ? exp_word(20 + t - 2) : 32'h0);
        end
        tick();
        repeat (8) tick();

        // Random traffic with a reset pulse in the middle
        for (int c = 0; c < 800; c++) begin
            request    = ($urandom_range(0, 3) != 0);
            we_re      = ($urandom_range(0, 2) == 0);
            mask       = 4'($urandom);
            address    = 8'($urandom);
            data_in    = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            rst        = !(c >= 400 && c < 402);
            tick();
        end
        rst = 1'b1; request = 1'b0; resp_ready = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
